adc_sample_streamer: RTL and testbench
======================================

// Module: adc_sample_streamer
// PURPOSE
//  Waveform/sample engine of the ADC simulator IP. Sits directly downstream of the
//  AXI4-Lite register bank: consumes its config registers, generates synthetic ADC
//  samples at a programmable rate, buffers them in a small FIFO and emits packetised
//  AXI4-Stream data to the capture path. Reports FIFO overflow and busy status.
// PARAMETERS
//  DATA_WIDTH  16  sample width (tdata width)
//  FIFO_DEPTH  16  sample FIFO entries, power of two, >=4
//  DIV_WIDTH   16  width of sample-rate divider
//  PKT_WIDTH   12  width of packet-length field
// PORTS
//  ACLK           in   1                      single clock, all logic rising-edge
//  ARESET         in   1                      synchronous reset, active-high
//  cfg_enable     in   1                      run request (level)
//  cfg_mode       in   2                      00 ramp, 01 triangle, 10 constant, 11 = ramp
//  cfg_divider    in   DIV_WIDTH              one sample every cfg_divider+1 cycles
//  cfg_step       in   DATA_WIDTH             ramp/triangle increment; constant value
//  cfg_pkt_len    in   PKT_WIDTH              samples per packet minus 1
//  clear_ovf      in   1                      1-cycle pulse, clears overflow
//  m_axis_tdata   out  DATA_WIDTH             sample
//  m_axis_tvalid  out  1                      sample valid
//  m_axis_tready  in   1                      downstream ready
//  m_axis_tlast   out  1                      last sample of packet
//  overflow       out  1                      sticky: sample dropped on full FIFO
//  fifo_level     out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//  busy           out  1                      high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FIFO flushed, state IDLE, wave value 0, dir up, counters 0.
//  FSM IDLE/RUN/FINISH/DRAIN:
//   IDLE->RUN when cfg_enable=1; latch mode/divider/step/pkt_len; div_cnt=0, pkt_cnt=0,
//     value=0, dir=up. Config is ignored outside IDLE.
//   RUN: div_cnt counts 0..divider; strobe when div_cnt==divider (then div_cnt=0).
//     First strobe divider+1 cycles after RUN entry; first sample value is 0.
//   RUN->FINISH on cfg_enable=0 with pkt_cnt!=0; RUN->DRAIN on cfg_enable=0 with pkt_cnt==0.
//   FINISH: keep strobing until the tlast sample is written/consumed by counter -> DRAIN.
//   DRAIN: no strobes; -> IDLE when FIFO empty. cfg_enable=1 in DRAIN ignored.
//  On strobe: push {value, pkt_cnt==pkt_len}; then update value:
//   ramp: value+=step mod 2^DATA_WIDTH. constant: value=step (first sample still 0).
//   triangle up: value>max-step -> value=max, dir=down; else value+=step.
//   triangle down: value<step -> value=0, dir=up; else value-=step.
//  pkt_cnt: increments on successful push, wraps to 0 after pkt_len.
//  Full FIFO at strobe: sample dropped, overflow<=1; value still advances (time-true),
//   pkt_cnt does NOT advance (packets keep full length). Full = registered level==DEPTH;
//   a same-cycle pop does not rescue the write.
//  overflow set and clear_ovf same cycle: set wins.
//  FIFO: push at strobe cycle N -> tvalid earliest at N+1 (registered output).
//   Pop on tvalid&&tready. tdata/tlast stable while tvalid && !tready. fifo_level
//   updates the cycle after push/pop; simultaneous push+pop leaves level unchanged.
//  ARESET mid-operation: same as reset above, pending samples discarded, effective next edge.
// TESTING
//  1 ramp, div=3, step=5, len=3, tready=1 -> tdata 0,5,10,15 four cycles apart, tlast on 15; next 20.
//  2 ramp, step=0x4000 -> 0,0x4000,0x8000,0xC000,0x0000 (wrap), no overflow.
//  3 triangle, step=0x7000 -> 0,0x7000,0xE000,0xFFFF,0x8FFF,0x1FFF,0x0000,0x7000.
//  4 div=0, step=1, tready=0 -> level=16, 17th strobe sets overflow; tready=1 -> 0..15 then 17
//    (16 dropped); clear_ovf -> overflow=0.
//  5 len=7, cfg_enable=0 after 3 samples -> 5 more samples, tlast on 8th, busy=0 after FIFO empty.
//  6 ARESET=1 for 1 cycle mid-RUN with level=5 -> next cycle tvalid=0, level=0, overflow=0, busy=0.

Source files
------------

// File: rtl/adc_sample_streamer_if.sv
// AXI4-Stream master/slave bundle carrying generated ADC samples to the capture path.
interface adc_sample_streamer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_sample_streamer.sv
// Synthetic ADC waveform generator: rate-divided ramp/triangle/constant samples,
// buffered in a small FIFO and emitted as packetised AXI4-Stream.
module adc_sample_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int PKT_WIDTH  = 12
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          cfg_enable,
  input  logic [1:0]                    cfg_mode,
  input  logic [DIV_WIDTH-1:0]          cfg_divider,
  input  logic [DATA_WIDTH-1:0]         cfg_step,
  input  logic [PKT_WIDTH-1:0]          cfg_pkt_len,
  input  logic                          clear_ovf,
  adc_sample_streamer_if.master         m_axis,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]      FULL_LEVEL = LVL_W'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] MAX_VAL    = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  localparam logic [1:0] MODE_TRI   = 2'b01;
  localparam logic [1:0] MODE_CONST = 2'b10;

  logic [1:0]            state_reg, state_next;
  logic [1:0]            mode_reg;
  logic [DIV_WIDTH-1:0]  divider_reg;
  logic [DATA_WIDTH-1:0] step_reg;
  logic [PKT_WIDTH-1:0]  pkt_len_reg;
  logic [DIV_WIDTH-1:0]  div_cnt_reg;
  logic [PKT_WIDTH-1:0]  pkt_cnt_reg, pkt_cnt_next;
  logic [DATA_WIDTH-1:0] value_reg, value_next;
  logic                  dir_down_reg, dir_down_next;
  logic                  overflow_reg;

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]      level_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_last_reg;
  logic                  out_valid_reg;

  logic generating, strobe, fifo_full, push, drop, pop, pkt_last;
  logic mem_empty, load_out, mem_write;

  assign generating = (state_reg == ST_RUN) || (state_reg == ST_FINISH);
  assign strobe     = generating && (div_cnt_reg == divider_reg);
  assign fifo_full  = (level_reg == FULL_LEVEL);
  assign push       = strobe && !fifo_full;
  assign drop       = strobe && fifo_full;
  assign pop        = out_valid_reg && m_axis.tready;
  assign pkt_last   = (pkt_cnt_reg == pkt_len_reg);

  // The output register is one FIFO slot; the RAM never holds more than DEPTH-1
  // entries, so equal pointers always mean the RAM part is empty.
  assign mem_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign load_out   = !out_valid_reg || pop;
  assign mem_write  = push && !(load_out && mem_empty);

  always_comb begin
    pkt_cnt_next = pkt_cnt_reg;
    if (push) begin
      pkt_cnt_next = pkt_last ? '0 : pkt_cnt_reg + PKT_WIDTH'(1);
    end
  end

  // Value advances on every strobe, even when the sample is dropped.
  always_comb begin
    value_next    = value_reg;
    dir_down_next = dir_down_reg;
    if (strobe) begin
      case (mode_reg)
        MODE_TRI: begin
          if (!dir_down_reg) begin
            if (value_reg > (MAX_VAL - step_reg)) begin
              value_next    = MAX_VAL;
              dir_down_next = 1'b1;
            end else begin
              value_next = value_reg + step_reg;
            end
          end else begin
            if (value_reg < step_reg) begin
              value_next    = '0;
              dir_down_next = 1'b0;
            end else begin
              value_next = value_reg - step_reg;
            end
          end
        end
        MODE_CONST: value_next = step_reg;
        default:    value_next = value_reg + step_reg;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (cfg_enable) state_next = ST_RUN;
      ST_RUN:    if (!cfg_enable) state_next = (pkt_cnt_next == '0) ? ST_DRAIN : ST_FINISH;
      ST_FINISH: if (push && pkt_last) state_next = ST_DRAIN;
      default:   if (level_reg == '0) state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= '0;
      divider_reg  <= '0;
      step_reg     <= '0;
      pkt_len_reg  <= '0;
      div_cnt_reg  <= '0;
      pkt_cnt_reg  <= '0;
      value_reg    <= '0;
      dir_down_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE) begin
        if (cfg_enable) begin
          mode_reg     <= cfg_mode;
          divider_reg  <= cfg_divider;
          step_reg     <= cfg_step;
          pkt_len_reg  <= cfg_pkt_len;
          div_cnt_reg  <= '0;
          pkt_cnt_reg  <= '0;
          value_reg    <= '0;
          dir_down_reg <= 1'b0;
        end
      end else if (generating) begin
        div_cnt_reg  <= strobe ? '0 : div_cnt_reg + DIV_WIDTH'(1);
        pkt_cnt_reg  <= pkt_cnt_next;
        value_reg    <= value_next;
        dir_down_reg <= dir_down_next;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_write) begin
      mem[wr_ptr_reg] <= {value_reg, pkt_last};
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (mem_write) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (load_out) begin
        if (!mem_empty) begin
          {out_data_reg, out_last_reg} <= mem[rd_ptr_reg];
          out_valid_reg                <= 1'b1;
          rd_ptr_reg                   <= rd_ptr_reg + PTR_W'(1);
        end else if (push) begin
          // Bypass keeps push-to-tvalid at one cycle when the RAM is empty.
          out_data_reg  <= value_reg;
          out_last_reg  <= pkt_last;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign m_axis.tdata  = out_data_reg;
  assign m_axis.tlast  = out_last_reg;
  assign m_axis.tvalid = out_valid_reg;
  assign overflow      = overflow_reg;
  assign fifo_level    = level_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adc_sample_streamer.sv
// Directed bench for adc_sample_streamer: waveform shapes, pacing, packets,
// overflow handling, end-of-run draining and mid-run reset.
module tb_adc_sample_streamer;

  logic        ACLK;
  logic        ARESET;
  logic        cfg_enable;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_divider;
  logic [15:0] cfg_step;
  logic [11:0] cfg_pkt_len;
  logic        clear_ovf;
  logic        overflow;
  logic [4:0]  fifo_level;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  adc_sample_streamer_if #(.DATA_WIDTH(16)) axis ();

  adc_sample_streamer #(
    .DATA_WIDTH(16), .FIFO_DEPTH(16), .DIV_WIDTH(16), .PKT_WIDTH(12)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .cfg_enable  (cfg_enable),
    .cfg_mode    (cfg_mode),
    .cfg_divider (cfg_divider),
    .cfg_step    (cfg_step),
    .cfg_pkt_len (cfg_pkt_len),
    .clear_ovf   (clear_ovf),
    .m_axis      (axis.master),
    .overflow    (overflow),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET     = 1'b1;
    cfg_enable = 1'b0;
    clear_ovf  = 1'b0;
    cycles(2);
    ARESET     = 1'b0;
  endtask

  task automatic start(input logic [1:0] m, input logic [15:0] d, input logic [15:0] s,
                       input logic [11:0] l);
    cfg_mode    = m;
    cfg_divider = d;
    cfg_step    = s;
    cfg_pkt_len = l;
    cfg_enable  = 1'b1;
  endtask

  // Waits (bounded) for a beat that will be accepted at the next edge, then consumes it.
  task automatic get_beat(input string tag, output logic [15:0] d, output logic l,
                          output int gap);
    gap = 0;
    while (!(axis.tvalid && axis.tready) && gap < 200) begin
      cycles(1);
      gap++;
    end
    if (gap >= 200) check({tag, "_timeout"}, {31'd0, axis.tvalid}, 32'd1);
    d = axis.tdata;
    l = axis.tlast;
    $display("beat %s: tdata=0x%04h tlast=%0d gap=%0d", tag, d, l, gap);
    cycles(1);
  endtask

  task automatic wait_level(input logic [4:0] target, input int limit);
    int n = 0;
    while (fifo_level !== target && n < limit) begin
      cycles(1);
      n++;
    end
    check("wait_level", {27'd0, fifo_level}, {27'd0, target});
  endtask

  logic [15:0] d;
  logic        l;
  int          gap;
  logic [15:0] exp_ramp   [5] = '{16'd0, 16'd5, 16'd10, 16'd15, 16'd20};
  logic        exp_last1  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] exp_wrap   [5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
  logic [15:0] exp_tri    [8] = '{16'h0000, 16'h7000, 16'hE000, 16'hFFFF,
                                  16'h8FFF, 16'h1FFF, 16'h0000, 16'h7000};

  initial begin
    ARESET      = 1'b1;
    cfg_enable  = 1'b0;
    cfg_mode    = 2'b00;
    cfg_divider = '0;
    cfg_step    = '0;
    cfg_pkt_len = '0;
    clear_ovf   = 1'b0;
    axis.tready = 1'b0;
    cycles(3);
    ARESET = 1'b0;

    check("rst_tvalid",   {31'd0, axis.tvalid}, 32'd0);
    check("rst_tdata",    {16'd0, axis.tdata},  32'd0);
    check("rst_tlast",    {31'd0, axis.tlast},  32'd0);
    check("rst_overflow", {31'd0, overflow},    32'd0);
    check("rst_level",    {27'd0, fifo_level},  32'd0);
    check("rst_busy",     {31'd0, busy},        32'd0);

    // Ramp with divider 3: first beat 5 cycles after enable, then every 4 cycles.
    axis.tready = 1'b1;
    start(2'b00, 16'd3, 16'd5, 12'd3);
    for (int i = 0; i < 5; i++) begin
      get_beat("ramp", d, l, gap);
      check("ramp_data", {16'd0, d}, {16'd0, exp_ramp[i]});
      check("ramp_last", {31'd0, l}, {31'd0, exp_last1[i]});
      check("ramp_gap",  gap, (i == 0) ? 32'd5 : 32'd3);
      if (i == 0) begin
        cfg_step = 16'd7;
        cfg_mode = 2'b10;
      end
    end
    check("ramp_busy",     {31'd0, busy},     32'd1);
    check("ramp_overflow", {31'd0, overflow}, 32'd0);
    do_reset();

    // Ramp wrap-around at full rate.
    start(2'b00, 16'd0, 16'h4000, 12'd15);
    for (int i = 0; i < 5; i++) begin
      get_beat("wrap", d, l, gap);
      check("wrap_data", {16'd0, d}, {16'd0, exp_wrap[i]});
    end
    check("wrap_overflow", {31'd0, overflow}, 32'd0);
    do_reset();

    // Triangle saturating at both ends.
    start(2'b01, 16'd1, 16'h7000, 12'd15);
    for (int i = 0; i < 8; i++) begin
      get_beat("tri", d, l, gap);
      check("tri_data", {16'd0, d}, {16'd0, exp_tri[i]});
    end
    do_reset();

    // Overflow: fill with tready low, drop sample 16, clear_ovf loses to a same-cycle set.
    axis.tready = 1'b0;
    start(2'b00, 16'd0, 16'd1, 12'd15);
    wait_level(5'd16, 40);
    check("ovf_before", {31'd0, overflow}, 32'd0);
    axis.tready = 1'b1;
    clear_ovf   = 1'b1;
    get_beat("ovf", d, l, gap);
    clear_ovf = 1'b0;
    check("ovf_data0",   {16'd0, d},        32'd0);
    check("ovf_setwins", {31'd0, overflow}, 32'd1);
    for (int i = 1; i < 17; i++) begin
      get_beat("ovf", d, l, gap);
      check("ovf_data", {16'd0, d}, (i < 16) ? i : i + 1);
    end
    clear_ovf = 1'b1;
    cycles(1);
    clear_ovf = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    do_reset();

    // Disable mid-packet: the packet of 8 completes, then drain to idle.
    start(2'b00, 16'd3, 16'd1, 12'd7);
    for (int i = 0; i < 3; i++) begin
      get_beat("fin", d, l, gap);
      check("fin_data", {16'd0, d}, i);
      check("fin_last", {31'd0, l}, 32'd0);
    end
    cfg_enable = 1'b0;
    for (int i = 3; i < 8; i++) begin
      get_beat("fin", d, l, gap);
      check("fin_data", {16'd0, d}, i);
      check("fin_last", {31'd0, l}, (i == 7) ? 32'd1 : 32'd0);
    end
    for (int n = 0; n < 50 && busy !== 1'b0; n++) cycles(1);
    check("fin_busy",   {31'd0, busy},        32'd0);
    check("fin_tvalid", {31'd0, axis.tvalid}, 32'd0);
    check("fin_level",  {27'd0, fifo_level},  32'd0);

    // Reset while running with five samples queued.
    axis.tready = 1'b0;
    start(2'b00, 16'd0, 16'd1, 12'd15);
    wait_level(5'd5, 20);
    ARESET     = 1'b1;
    cfg_enable = 1'b0;
    cycles(1);
    ARESET = 1'b0;
    check("mrst_tvalid",   {31'd0, axis.tvalid}, 32'd0);
    check("mrst_level",    {27'd0, fifo_level},  32'd0);
    check("mrst_overflow", {31'd0, overflow},    32'd0);
    check("mrst_busy",     {31'd0, busy},        32'd0);
    check("mrst_tdata",    {16'd0, axis.tdata},  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
